brc_branch_resolve: RTL and testbench

- Consumer of the branch comparator flags (o_br_less/o_br_equal) in EX, and producer of the comparator's mode input (i_br_un).
- Decodes funct3 into taken/not-taken and detects mispredictions.
- Drives the flush/redirect to IF.
- Holds a direct-mapped branch history table (BHT, 2-bit saturating counters) and a branch target buffer (BTB) that supply next-PC predictions to IF. Also keeps branch and mispredict performance counters.

---
 rtl/brc_pkg.sv | 26 ++
 rtl/brc_branch_resolve_if.sv | 41 ++++
 rtl/bht_sat_ctr.sv | 19 +
 rtl/brc_branch_resolve.sv | 101 ++++++++++
 tb/tb_brc_branch_resolve.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/brc_pkg.sv
// Shared definitions for the branch resolve unit: funct3 encodings, BHT
// counter states and a funct3 legality helper.
package brc_pkg;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } bht_state_t;

  localparam bht_state_t BHT_RST = WNT;

  // funct3 010/011 are not conditional branches.
  function automatic logic f3_legal(input logic [2:0] f3);
    return f3[2:1] != 2'b01;
  endfunction

endpackage

// File: rtl/brc_branch_resolve_if.sv
// Signal bundle between the pipeline (IF prediction, EX resolution,
// comparator flags) and the branch resolve unit.
interface brc_branch_resolve_if #(parameter int DATA_WIDTH = 32);

  logic [DATA_WIDTH-1:0] i_if_pc;
  logic                  o_if_pred_taken;
  logic [DATA_WIDTH-1:0] o_if_pred_pc;
  logic                  i_ex_valid;
  logic                  i_ex_is_br;
  logic [2:0]            i_ex_funct3;
  logic [DATA_WIDTH-1:0] i_ex_pc;
  logic [DATA_WIDTH-1:0] i_ex_target;
  logic                  i_ex_pred_taken;
  logic [DATA_WIDTH-1:0] i_ex_pred_pc;
  logic                  o_br_un;
  logic                  i_br_less;
  logic                  i_br_equal;
  logic                  o_ex_taken;
  logic                  o_flush;
  logic [DATA_WIDTH-1:0] o_redirect_pc;
  logic                  o_illegal;
  logic [31:0]           o_br_cnt;
  logic [31:0]           o_mispred_cnt;

  // No valid/ready handshake: EX inputs are sampled every cycle and qualified
  // by i_ex_valid & i_ex_is_br; all outputs are combinational or registered state.
  modport master (
    output i_if_pc, i_ex_valid, i_ex_is_br, i_ex_funct3, i_ex_pc, i_ex_target,
           i_ex_pred_taken, i_ex_pred_pc, i_br_less, i_br_equal,
    input  o_if_pred_taken, o_if_pred_pc, o_br_un, o_ex_taken, o_flush,
           o_redirect_pc, o_illegal, o_br_cnt, o_mispred_cnt
  );

  modport slave (
    input  i_if_pc, i_ex_valid, i_ex_is_br, i_ex_funct3, i_ex_pc, i_ex_target,
           i_ex_pred_taken, i_ex_pred_pc, i_br_less, i_br_equal,
    output o_if_pred_taken, o_if_pred_pc, o_br_un, o_ex_taken, o_flush,
           o_redirect_pc, o_illegal, o_br_cnt, o_mispred_cnt
  );

endinterface

// File: rtl/bht_sat_ctr.sv
// 2-bit saturating up/down counter next-state function for BHT entries.
module bht_sat_ctr
  import brc_pkg::*;
(
  input  bht_state_t i_ctr,
  input  logic       i_taken,
  output bht_state_t o_ctr
);

  always_comb begin
    o_ctr = i_ctr;
    if (i_taken) begin
      if (i_ctr != ST) o_ctr = bht_state_t'(i_ctr + 2'd1);
    end else begin
      if (i_ctr != SNT) o_ctr = bht_state_t'(i_ctr - 2'd1);
    end
  end

endmodule

// File: rtl/brc_branch_resolve.sv
// Branch resolution in EX plus BHT/BTB next-PC prediction for IF and
// branch/mispredict performance counters.
module brc_branch_resolve
  import brc_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int IDX_W      = 4
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  brc_branch_resolve_if.slave  bus
);

  localparam int N     = 1 << IDX_W;
  localparam int TAG_W = DATA_WIDTH - IDX_W - 2;

  logic [N-1:0]                  r_btb_valid;
  logic [N-1:0][TAG_W-1:0]       r_btb_tag;
  logic [N-1:0][DATA_WIDTH-1:0]  r_btb_tgt;
  bht_state_t [N-1:0]            r_bht;
  logic [31:0]                   r_br_cnt;
  logic [31:0]                   r_mispred_cnt;

  logic [IDX_W-1:0]      w_if_idx;
  logic [TAG_W-1:0]      w_if_tag;
  logic                  w_if_hit;
  logic [IDX_W-1:0]      w_ex_idx;
  logic [TAG_W-1:0]      w_ex_tag;
  logic                  w_br;
  logic                  w_legal;
  logic                  w_upd;
  logic                  w_cond;
  logic [DATA_WIDTH-1:0] w_actual_pc;
  bht_state_t            w_ctr_nxt;
  logic                  w_unused_bits;

  // Word-aligned PCs: bits [1:0] never participate in index or tag; the
  // carried prediction flag is redundant with the carried predicted PC.
  assign w_unused_bits = ^{bus.i_if_pc[1:0], bus.i_ex_pc[1:0], bus.i_ex_pred_taken};

  // IF-side prediction reads pre-edge table contents (no bypass from EX).
  assign w_if_idx            = bus.i_if_pc[IDX_W+1:2];
  assign w_if_tag            = bus.i_if_pc[DATA_WIDTH-1:IDX_W+2];
  assign w_if_hit            = r_btb_valid[w_if_idx] && (r_btb_tag[w_if_idx] == w_if_tag);
  assign bus.o_if_pred_taken = w_if_hit & r_bht[w_if_idx][1];
  assign bus.o_if_pred_pc    = bus.o_if_pred_taken ? r_btb_tgt[w_if_idx]
                                                   : bus.i_if_pc + DATA_WIDTH'(4);

  assign w_ex_idx = bus.i_ex_pc[IDX_W+1:2];
  assign w_ex_tag = bus.i_ex_pc[DATA_WIDTH-1:IDX_W+2];
  assign w_br     = bus.i_ex_valid & bus.i_ex_is_br;
  assign w_legal  = f3_legal(bus.i_ex_funct3);
  assign w_upd    = w_br & w_legal;

  always_comb begin
    w_cond = 1'b0;
    case (bus.i_ex_funct3)
      F3_BEQ:          w_cond = bus.i_br_equal;
      F3_BNE:          w_cond = ~bus.i_br_equal;
      F3_BLT, F3_BLTU: w_cond = bus.i_br_less;
      F3_BGE, F3_BGEU: w_cond = ~bus.i_br_less;
      default:         w_cond = 1'b0;
    endcase
  end

  assign w_actual_pc       = w_cond ? bus.i_ex_target : bus.i_ex_pc + DATA_WIDTH'(4);
  assign bus.o_br_un       = bus.i_ex_funct3[1];
  assign bus.o_ex_taken    = w_upd & w_cond;
  assign bus.o_illegal     = w_br & ~w_legal;
  assign bus.o_flush       = w_upd & (bus.i_ex_pred_pc != w_actual_pc);
  assign bus.o_redirect_pc = w_upd ? w_actual_pc : '0;
  assign bus.o_br_cnt      = r_br_cnt;
  assign bus.o_mispred_cnt = r_mispred_cnt;

  bht_sat_ctr u_ctr (
    .i_ctr   (r_bht[w_ex_idx]),
    .i_taken (w_cond),
    .o_ctr   (w_ctr_nxt)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_btb_valid   <= '0;
      r_btb_tag     <= '0;
      r_btb_tgt     <= '0;
      for (int i = 0; i < N; i++) r_bht[i] <= BHT_RST;
      r_br_cnt      <= '0;
      r_mispred_cnt <= '0;
    end else if (w_upd) begin
      r_bht[w_ex_idx] <= w_ctr_nxt;
      if (w_cond) begin
        r_btb_valid[w_ex_idx] <= 1'b1;
        r_btb_tag[w_ex_idx]   <= w_ex_tag;
        r_btb_tgt[w_ex_idx]   <= bus.i_ex_target;
      end
      r_br_cnt <= r_br_cnt + 32'd1;
      if (bus.o_flush) r_mispred_cnt <= r_mispred_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_brc_branch_resolve.sv
// Directed + random bench for brc_branch_resolve against a table-based model.
module tb_brc_branch_resolve;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  // Reference model: plain arrays indexed by pc[5:2].
  int          m_ctr [16];
  bit          m_val [16];
  logic [25:0] m_tag [16];
  logic [31:0] m_tgt [16];
  logic [31:0] m_br;
  logic [31:0] m_mis;

  brc_branch_resolve_if #(.DATA_WIDTH(32)) bus ();

  brc_branch_resolve #(.DATA_WIDTH(32), .IDX_W(4)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      m_ctr[i] = 1;
      m_val[i] = 0;
      m_tag[i] = '0;
      m_tgt[i] = '0;
    end
    m_br  = 0;
    m_mis = 0;
  endtask

  function automatic logic [31:0] model_pred_pc(input logic [31:0] pc, output bit taken);
    int idx;
    idx   = int'(pc[5:2]);
    taken = m_val[idx] && (m_tag[idx] == pc[31:6]) && (m_ctr[idx] >= 2);
    return taken ? m_tgt[idx] : pc + 32'd4;
  endfunction

  task automatic check_pred(input logic [31:0] ifpc);
    bit          e_t;
    logic [31:0] e_pc;
    e_pc = model_pred_pc(ifpc, e_t);
    chk("pred_taken", {31'd0, bus.o_if_pred_taken}, {31'd0, e_t});
    chk("pred_pc", bus.o_if_pred_pc, e_pc);
  endtask

  // One EX cycle: drive operands a/b, derive comparator flags, check the
  // combinational outputs, then the registered counters after the edge.
  task automatic resolve(input bit v, input bit br, input logic [2:0] f3,
                         input logic [31:0] pc, input logic [31:0] tgt,
                         input logic [31:0] ppc, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] ifpc);
    bit          legal, t, e_upd, e_flush, ptk;
    logic [31:0] e_act, dummy;
    int          idx;
    @(negedge clk);
    dummy               = model_pred_pc(ppc, ptk);
    bus.i_if_pc         = ifpc;
    bus.i_ex_valid      = v;
    bus.i_ex_is_br      = br;
    bus.i_ex_funct3     = f3;
    bus.i_ex_pc         = pc;
    bus.i_ex_target     = tgt;
    bus.i_ex_pred_pc    = ppc;
    bus.i_ex_pred_taken = (ppc != pc + 32'd4);
    bus.i_br_equal      = (a == b);
    bus.i_br_less       = f3[1] ? (a < b) : ($signed(a) < $signed(b));
    #1;
    legal = (f3 != 3'b010) && (f3 != 3'b011);
    case (f3)
      3'b000:  t = (a == b);
      3'b001:  t = (a != b);
      3'b100:  t = $signed(a) <  $signed(b);
      3'b101:  t = $signed(a) >= $signed(b);
      3'b110:  t = a <  b;
      3'b111:  t = a >= b;
      default: t = 0;
    endcase
    e_upd   = v && br && legal;
    e_act   = t ? tgt : pc + 32'd4;
    e_flush = e_upd && (ppc != e_act);
    check_pred(ifpc);
    chk("ex_taken", {31'd0, bus.o_ex_taken}, {31'd0, e_upd && t});
    chk("flush", {31'd0, bus.o_flush}, {31'd0, e_flush});
    chk("redirect", bus.o_redirect_pc, e_upd ? e_act : 32'd0);
    chk("illegal", {31'd0, bus.o_illegal}, {31'd0, v && br && !legal});
    chk("br_un", {31'd0, bus.o_br_un}, {31'd0, f3[1]});
    if (e_upd) begin
      idx = int'(pc[5:2]);
      m_ctr[idx] = t ? ((m_ctr[idx] == 3) ? 3 : m_ctr[idx] + 1)
                     : ((m_ctr[idx] == 0) ? 0 : m_ctr[idx] - 1);
      if (t) begin
        m_val[idx] = 1;
        m_tag[idx] = pc[31:6];
        m_tgt[idx] = tgt;
      end
      m_br = m_br + 1;
      if (e_flush) m_mis = m_mis + 1;
    end
    @(posedge clk);
    #1;
    bus.i_ex_valid = 0;
    chk("br_cnt", bus.o_br_cnt, m_br);
    chk("mispred_cnt", bus.o_mispred_cnt, m_mis);
  endtask

  task automatic pred_only(input logic [31:0] ifpc);
    @(negedge clk);
    bus.i_if_pc = ifpc;
    #1;
    check_pred(ifpc);
  endtask

  initial begin
    logic [31:0] pc, tgt, ppc, a, b;
    logic [2:0]  f3;
    bit          ptk;
    total = 0;
    bad   = 0;
    bus.i_if_pc = 32'h100; bus.i_ex_valid = 0; bus.i_ex_is_br = 0;
    bus.i_ex_funct3 = 0; bus.i_ex_pc = 0; bus.i_ex_target = 0;
    bus.i_ex_pred_taken = 0; bus.i_ex_pred_pc = 0;
    bus.i_br_less = 0; bus.i_br_equal = 0;
    model_reset();
    rst_n = 0;
    #12;
    check_pred(32'h100);
    chk("rst_br_cnt", bus.o_br_cnt, 32'd0);
    chk("rst_mis_cnt", bus.o_mispred_cnt, 32'd0);
    @(negedge clk);
    rst_n = 1;

    // Reset state, then first BEQ mispredict and trained prediction.
    pred_only(32'h100);
    chk("pred_after_rst_pc", bus.o_if_pred_pc, 32'h104);
    resolve(1, 1, 3'b000, 32'h100, 32'h80, 32'h104, 5, 5, 32'h100);
    pred_only(32'h100);
    chk("trained_pred_pc", bus.o_if_pred_pc, 32'h80);
    chk("mis_one", bus.o_mispred_cnt, 32'd1);

    // BLTU saturation: 4 taken, 1 not-taken, predictions from the model.
    for (int i = 0; i < 4; i++) begin
      ppc = model_pred_pc(32'h200, ptk);
      resolve(1, 1, 3'b110, 32'h200, 32'h40, ppc, 1, 9, 32'h200);
    end
    ppc = model_pred_pc(32'h200, ptk);
    resolve(1, 1, 3'b110, 32'h200, 32'h40, ppc, 9, 1, 32'h200);
    chk("sat_redirect_seen_pred", bus.o_if_pred_pc, 32'h40);

    // Illegal funct3 and comparator mode.
    resolve(1, 1, 3'b011, 32'h300, 32'h30, 32'h304, 1, 1, 32'h300);
    resolve(1, 1, 3'b010, 32'h300, 32'h30, 32'h304, 1, 2, 32'h300);
    resolve(1, 1, 3'b100, 32'h300, 32'h30, 32'h304, 32'hFFFF_FFFF, 1, 32'h300);
    resolve(0, 1, 3'b000, 32'h300, 32'h30, 32'h304, 1, 1, 32'h300);
    resolve(1, 0, 3'b000, 32'h300, 32'h30, 32'h304, 1, 1, 32'h300);

    // Aliasing 0x100 / 0x500, with same-cycle read of the written index.
    resolve(1, 1, 3'b001, 32'h100, 32'h80, 32'h80, 1, 2, 32'h500);
    pred_only(32'h500);
    resolve(1, 1, 3'b001, 32'h500, 32'h600, 32'h504, 1, 2, 32'h500);
    pred_only(32'h100);
    pred_only(32'h500);

    // PC wrap on not-taken at the top of the address space.
    resolve(1, 1, 3'b000, 32'hFFFF_FFFC, 32'h10, 32'h10, 1, 2, 32'hFFFF_FFFC);

    // Random traffic over a few indices and two tags per index.
    for (int n = 0; n < 300; n++) begin
      pc  = {($urandom_range(0, 1) != 0) ? 26'h4 : 26'h14, 4'($urandom_range(0, 3)), 2'b00};
      tgt = ($urandom_range(0, 3) == 0) ? ($urandom & 32'hFFFF_FFFC) : (pc ^ 32'h0000_0F00);
      f3  = 3'($urandom_range(0, 7));
      a   = {$urandom_range(0, 1) != 0, 29'd0, 2'($urandom_range(0, 3))};
      b   = {$urandom_range(0, 1) != 0, 29'd0, 2'($urandom_range(0, 3))};
      if ($urandom_range(0, 3) != 0) ppc = model_pred_pc(pc, ptk);
      else ppc = ($urandom_range(0, 1) != 0) ? pc + 32'd4 : tgt;
      resolve($urandom_range(0, 7) != 0, $urandom_range(0, 7) != 0, f3, pc, tgt, ppc, a, b,
              {($urandom_range(0, 1) != 0) ? 26'h4 : 26'h14, 4'($urandom_range(0, 3)), 2'b00});
    end

    // Mid-stream reset after training.
    resolve(1, 1, 3'b000, 32'h100, 32'h80, 32'h104, 3, 3, 32'h100);
    resolve(1, 1, 3'b000, 32'h100, 32'h80, 32'h80, 3, 3, 32'h100);
    @(negedge clk);
    bus.i_if_pc = 32'h100;
    #2;
    rst_n = 0;
    #1;
    chk("midrst_pred_taken", {31'd0, bus.o_if_pred_taken}, 32'd0);
    chk("midrst_pred_pc", bus.o_if_pred_pc, 32'h104);
    chk("midrst_br_cnt", bus.o_br_cnt, 32'd0);
    chk("midrst_mis_cnt", bus.o_mispred_cnt, 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1;
    pred_only(32'h100);
    pred_only(32'h200);

    // Branch counter wrap from all-ones.
    @(negedge clk);
    force dut.r_br_cnt = 32'hFFFF_FFFF;
    #1;
    release dut.r_br_cnt;
    m_br = 32'hFFFF_FFFF;
    resolve(1, 1, 3'b101, 32'h240, 32'h20, 32'h244, 1, 2, 32'h240);
    chk("br_cnt_wrapped", bus.o_br_cnt, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    bad++;
    $display("FAIL timeout observed=running expected=finished");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule
